// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//
// Integer register file for the pipelined core, with a per-register busy
// scoreboard and a hardware clear sweep after reset.
//
//   - Two combinational read ports with an optional same-cycle write bypass.
//   - One synchronous write port.
//   - Busy bits are set when an instruction issues and cleared at writeback.
//   - After reset, every entry is zeroed, one per cycle. No writes or issues
//     are accepted until the sweep finishes.
//
// Parameters
//   XLEN      data width of each register
//   AW        address width; the file holds 2**AW entries
//   ZERO_REG  1: entry 0 always reads 0, is never written and is never busy
//   BYPASS    1: a write is forwarded to matching read ports in the same cycle
//
// Ports
//   clk                 clock; all state updates on the rising edge
//   reset               synchronous, active-high; restarts the clear sweep
//   ready               high once the sweep is done and traffic is accepted
//   rs1_addr, rs2_addr  read addresses
//   rs1_data, rs2_data  read data (combinational)
//   rs1_busy, rs2_busy  scoreboard bits for the read addresses (registered
//                       state only)
//   we, waddr, wdata    write port; the write also clears busy[waddr]
//   iss_valid, iss_rd   issue strobe; sets busy[iss_rd]
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd
);

  localparam int NREGS = 2 ** AW;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t              stateQ, stateD;
  logic [AW-1:0]       sweepCntQ, sweepCntD;
  logic [NREGS-1:0]    busyQ, busyD;
  logic [XLEN-1:0]     regsQ [NREGS];

  logic                running;
  logic                wrDrop;
  logic                userWr;
  logic                memWe;
  logic [AW-1:0]       memAddr;
  logic [XLEN-1:0]     memData;

  assign running = (stateQ == RUN);
  assign ready   = running;

  // A write to entry 0 is discarded when that entry is hardwired to zero.
  assign wrDrop = (ZERO_REG != 0) && (waddr == '0);

  // A write from the user port that actually lands in the array. The reset
  // cycle is excluded so that reset always takes priority over traffic.
  assign userWr = running && we && !wrDrop && !reset;

  // The array has a single write port, shared by the sweep and the user.
  // The two never collide because the sweep only runs in CLEAR and user
  // writes only land in RUN.
  always_comb begin
    memWe   = 1'b0;
    memAddr = waddr;
    memData = wdata;
    if (!reset && (stateQ == CLEAR)) begin
      memWe   = 1'b1;
      memAddr = sweepCntQ;
      memData = '0;
    end else if (userWr) begin
      memWe   = 1'b1;
      memAddr = waddr;
      memData = wdata;
    end
  end

  // The array itself has no reset. The clear sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (memWe) begin
      regsQ[memAddr] <= memData;
    end
  end

  // Next state and sweep counter. The counter steps once per CLEAR cycle.
  // Leaving CLEAR is the only way it wraps back to 0.
  always_comb begin
    stateD    = stateQ;
    sweepCntD = sweepCntQ;
    unique case (stateQ)
      CLEAR: begin
        sweepCntD = sweepCntQ + AW'(1);
        if (sweepCntQ == {AW{1'b1}}) begin
          stateD = RUN;
        end
      end
      RUN: begin
        sweepCntD = '0;
      end
      default: begin
        stateD    = CLEAR;
        sweepCntD = '0;
      end
    endcase
  end

  // Scoreboard update. The clear is applied before the set, so an issue and
  // a writeback to the same register in one cycle leave it busy.
  always_comb begin
    busyD = busyQ;
    if (running) begin
      if (we) begin
        busyD[waddr] = 1'b0;
      end
      if (iss_valid) begin
        busyD[iss_rd] = 1'b1;
      end
    end else begin
      busyD = '0;
    end
    if (ZERO_REG != 0) begin
      busyD[0] = 1'b0;
    end
  end

  // State, counter and scoreboard registers. Reset holds the counter at 0,
  // so the sweep starts cleanly once reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= CLEAR;
      sweepCntQ <= '0;
      busyQ     <= '0;
    end else begin
      stateQ    <= stateD;
      sweepCntQ <= sweepCntD;
      busyQ     <= busyD;
    end
  end

  // Read port 1. While the sweep runs, the output is forced to zero because
  // the array may still hold stale contents.
  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (running) begin
      rs1_busy = busyQ[rs1_addr];
      if ((ZERO_REG != 0) && (rs1_addr == '0)) begin
        rs1_data = '0;
      end else if ((BYPASS != 0) && userWr && (waddr == rs1_addr)) begin
        rs1_data = wdata;
      end else begin
        rs1_data = regsQ[rs1_addr];
      end
    end
  end

  // Read port 2 works the same way as read port 1.
  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (running) begin
      rs2_busy = busyQ[rs2_addr];
      if ((ZERO_REG != 0) && (rs2_addr == '0)) begin
        rs2_data = '0;
      end else if ((BYPASS != 0) && userWr && (waddr == rs2_addr)) begin
        rs2_data = wdata;
      end else begin
        rs2_data = regsQ[rs2_addr];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//
// Testbench for regfile_sb. Two instances share the same inputs: one with
// the write bypass enabled and one without it.
//
// Stimulus is applied shortly after each rising edge. Each expected value is
// queued together with the cycle in which it must hold. A monitor samples
// the outputs on the falling edge, pops the entries due that cycle and
// compares them.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam int SEL_READY = 0;
  localparam int SEL_D1    = 1;
  localparam int SEL_D2    = 2;
  localparam int SEL_B1    = 3;
  localparam int SEL_B2    = 4;
  localparam int SEL_NB_D1 = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            ready, readyNb;
  logic [AW-1:0]   rs1Addr, rs2Addr;
  logic [XLEN-1:0] rs1Data, rs2Data, rs1DataNb, rs2DataNb;
  logic            rs1Busy, rs2Busy, rs1BusyNb, rs2BusyNb;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic            issValid;
  logic [AW-1:0]   issRd;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] expv;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  int   cycleCnt = 0;
  int   total    = 0;
  int   bad      = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt = cycleCnt + 1;

  regfile_sb #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .rs1_addr(rs1Addr), .rs2_addr(rs2Addr),
    .rs1_data(rs1Data), .rs2_data(rs2Data),
    .rs1_busy(rs1Busy), .rs2_busy(rs2Busy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .iss_valid(issValid), .iss_rd(issRd)
  );

  regfile_sb #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1), .BYPASS(0)) dutNb (
    .clk(clk), .reset(reset), .ready(readyNb),
    .rs1_addr(rs1Addr), .rs2_addr(rs2Addr),
    .rs1_data(rs1DataNb), .rs2_data(rs2DataNb),
    .rs1_busy(rs1BusyNb), .rs2_busy(rs2BusyNb),
    .we(we), .waddr(waddr), .wdata(wdata),
    .iss_valid(issValid), .iss_rd(issRd)
  );

  function automatic logic [31:0] getActual(input int sel);
    case (sel)
      SEL_READY: return {31'd0, ready};
      SEL_D1:    return rs1Data;
      SEL_D2:    return rs2Data;
      SEL_B1:    return {31'd0, rs1Busy};
      SEL_B2:    return {31'd0, rs2Busy};
      SEL_NB_D1: return rs1DataNb;
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: compares every expectation that is due in the current cycle.
  // An entry whose cycle has already passed counts as a failure.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (expQ.size() > 0 && expQ[0].cyc <= cycleCnt) begin
      e = expQ.pop_front();
      total = total + 1;
      if (e.cyc < cycleCnt) begin
        bad = bad + 1;
        $display("[TB] FAIL %s: stale check for cycle %0d at cycle %0d", e.name, e.cyc, cycleCnt);
      end else begin
        act = getActual(e.sel);
        if (act !== e.expv) begin
          bad = bad + 1;
          $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h (cycle %0d)", e.name, act, e.expv, cycleCnt);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                               input logic iv, input logic [AW-1:0] ir,
                               input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    we = w; waddr = wa; wdata = wd;
    issValid = iv; issRd = ir;
    rs1Addr = a1; rs2Addr = a2;
  endtask

  task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, a1, a2);
  endtask

  // Queue an expectation for the cycle that is currently being driven.
  task automatic checkOutput(input string name, input int sel, input logic [31:0] expv);
    exp_t e;
    e.name = name; e.sel = sel; e.expv = expv; e.cyc = cycleCnt;
    expQ.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    idle(5'd0, 5'd0);

    // Hold reset for three cycles.
    step();
    checkOutput("reset_ready", SEL_READY, 32'd0);
    checkOutput("reset_busy1", SEL_B1, 32'd0);
    checkOutput("reset_data1", SEL_D1, 32'd0);
    step();
    step();
    reset = 1'b0;

    // The sweep runs for 32 cycles. A write to x5 and an issue of x6 in the
    // middle of the sweep must both be ignored.
    for (int i = 0; i < 32; i++) begin
      if (i == 10) applyStimulus(1'b1, 5'd5, 32'hAAAA_5555, 1'b1, 5'd6, 5'd5, 5'd6);
      else         idle(5'd5, 5'd6);
      checkOutput("sweep_ready", SEL_READY, 32'd0);
      checkOutput("sweep_data1", SEL_D1, 32'd0);
      step();
    end
    idle(5'd0, 5'd1);
    checkOutput("run_ready", SEL_READY, 32'd1);

    // After the sweep, every entry reads 0 and none is busy.
    for (int i = 0; i < 16; i++) begin
      idle(AW'(2 * i), AW'(2 * i + 1));
      checkOutput("clear_even", SEL_D1, 32'd0);
      checkOutput("clear_odd", SEL_D2, 32'd0);
      checkOutput("clear_busy_even", SEL_B1, 32'd0);
      checkOutput("clear_busy_odd", SEL_B2, 32'd0);
      step();
    end

    // Write x3 and attempt to write x0, then read both.
    applyStimulus(1'b1, 5'd3, 32'h0000_0004, 1'b0, '0, 5'd1, 5'd2);
    step();
    applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, '0, 5'd3, 5'd0);
    checkOutput("x0_bypass", SEL_D2, 32'd0);
    step();
    idle(5'd3, 5'd0);
    checkOutput("x3_read", SEL_D1, 32'h4);
    checkOutput("x0_read", SEL_D2, 32'h0);
    step();

    // Bypass: the write to x11 is visible in the same cycle only when the
    // bypass is enabled.
    applyStimulus(1'b1, 5'd11, 32'h18, 1'b0, '0, 5'd11, 5'd0);
    checkOutput("bypass_on", SEL_D1, 32'h18);
    checkOutput("bypass_off_old", SEL_NB_D1, 32'h0);
    step();
    idle(5'd11, 5'd0);
    checkOutput("bypass_on_next", SEL_D1, 32'h18);
    checkOutput("bypass_off_next", SEL_NB_D1, 32'h18);
    step();

    // Scoreboard behaviour on x7.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 5'd0, 5'd7);
    checkOutput("busy_no_fwd", SEL_B2, 32'd0);
    step();
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd0, 5'd7);
    checkOutput("busy_set", SEL_B2, 32'd1);
    step();
    idle(5'd0, 5'd7);
    checkOutput("busy_set_wins", SEL_B2, 32'd1);
    step();
    applyStimulus(1'b1, 5'd7, 32'h78, 1'b0, '0, 5'd0, 5'd7);
    checkOutput("busy_clear_lag", SEL_B2, 32'd1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 5'd0, 5'd7);
    checkOutput("busy_cleared", SEL_B2, 32'd0);
    checkOutput("x7_data", SEL_D2, 32'h78);
    step();
    idle(5'd0, 5'd0);
    checkOutput("busy_x0", SEL_B1, 32'd0);
    step();

    // Reset in the middle of operation.
    applyStimulus(1'b1, 5'd8, 32'h4, 1'b1, 5'd16, 5'd8, 5'd16);
    step();
    idle(5'd8, 5'd16);
    checkOutput("pre_rst_x8", SEL_D1, 32'h4);
    checkOutput("pre_rst_busy16", SEL_B2, 32'd1);
    step();
    reset = 1'b1;
    checkOutput("rst_cycle_ready", SEL_READY, 32'd1);
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checkOutput("rst2_ready", SEL_READY, 32'd0);
      checkOutput("rst2_busy16", SEL_B2, 32'd0);
      step();
    end
    checkOutput("rst2_run", SEL_READY, 32'd1);
    checkOutput("rst2_x8", SEL_D1, 32'd0);
    checkOutput("rst2_busy16_run", SEL_B2, 32'd0);
    step();

    // Both read ports on the same address.
    applyStimulus(1'b1, 5'd22, 32'd19, 1'b0, '0, 5'd0, 5'd0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd22, 5'd22, 5'd22);
    checkOutput("dual_d1", SEL_D1, 32'd19);
    checkOutput("dual_d2", SEL_D2, 32'd19);
    checkOutput("dual_b1", SEL_B1, 32'd0);
    checkOutput("dual_b2", SEL_B2, 32'd0);
    step();
    idle(5'd22, 5'd22);
    checkOutput("dual_busy_b1", SEL_B1, 32'd1);
    checkOutput("dual_busy_b2", SEL_B2, 32'd1);
    step();

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) step();
    if (expQ.size() > 0) begin
      $display("[TB] FAIL drain: %0d checks left, wanted 0", expQ.size());
      total = total + expQ.size();
      bad   = bad + expQ.size();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
